// File: rtl/calc_pkg.sv
// Shared constants and saturation helpers for the multi-lane binary calc datapath.
package calc_pkg;

  localparam logic MODE_BIPOLAR  = 1'b0;
  localparam logic MODE_UNIPOLAR = 1'b1;

  localparam int DEF_ACC_W = 12;
  localparam int DEF_N_CH  = 4;

  // Largest and smallest values representable in a w-bit signed accumulator.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/calc_lane.sv
// One lane: XNOR contribution, saturating accumulator with sticky saturation flag.
module calc_lane
  import calc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic                    last,
  input  logic                    mode,
  input  logic                    w,
  input  logic                    x,
  input  logic signed [ACC_W-1:0] thr,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat,
  output logic                    acted
);

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_V = (ACC_W + 1)'(sat_min(ACC_W));

  logic signed [ACC_W-1:0] acc_reg;
  logic                    sat_reg;
  logic signed [ACC_W:0]   contrib;
  logic signed [ACC_W:0]   base;
  logic signed [ACC_W:0]   wide;
  logic                    clamp;

  always_comb begin
    contrib = '0;
    if (~(w ^ x))
      contrib = (ACC_W + 1)'(1);
    else if (mode == MODE_BIPOLAR)
      contrib = '1;
    base  = first ? '0 : {acc_reg[ACC_W-1], acc_reg};
    wide  = base + contrib;
    clamp = 1'b0;
    sum   = wide[ACC_W-1:0];
    if (wide > MAX_V) begin
      sum   = MAX_V[ACC_W-1:0];
      clamp = 1'b1;
    end else if (wide < MIN_V) begin
      sum   = MIN_V[ACC_W-1:0];
      clamp = 1'b1;
    end
    sat   = (first ? 1'b0 : sat_reg) | clamp;
    acted = (sum >= thr);
  end

  // The last beat hands its result to the output register and restarts the lane from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      sat_reg <= 1'b0;
    end else if (en) begin
      if (last) begin
        acc_reg <= '0;
        sat_reg <= 1'b0;
      end else begin
        acc_reg <= sum;
        sat_reg <= sat;
      end
    end
  end

endmodule

// File: rtl/calc_multi.sv
// N_CH-lane binary accumulate/threshold datapath with valid/ready input and one-entry output register.
module calc_multi
  import calc_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_mode,
  input  logic [N_CH-1:0]         in_w,
  input  logic [N_CH-1:0]         in_x,
  input  logic [ACC_W-1:0]        thr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*ACC_W-1:0]   out_acc,
  output logic [N_CH-1:0]         out_acted,
  output logic [N_CH-1:0]         out_sat
);

  logic                  accept;
  logic [N_CH*ACC_W-1:0] sum_next;
  logic [N_CH-1:0]       sat_next;
  logic [N_CH-1:0]       acted_next;
  logic                  out_valid_reg;
  logic [N_CH*ACC_W-1:0] out_acc_reg;
  logic [N_CH-1:0]       out_acted_reg;
  logic [N_CH-1:0]       out_sat_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      calc_lane #(.ACC_W(ACC_W)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .first (in_first),
        .last  (in_last),
        .mode  (in_mode),
        .w     (in_w[gi]),
        .x     (in_x[gi]),
        .thr   (thr),
        .sum   (sum_next[gi*ACC_W +: ACC_W]),
        .sat   (sat_next[gi]),
        .acted (acted_next[gi])
      );
    end
  endgenerate

  // A new last beat takes priority over a consume so results can stream back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_acc_reg   <= '0;
      out_acted_reg <= '0;
      out_sat_reg   <= '0;
    end else if (accept && in_last) begin
      out_valid_reg <= 1'b1;
      out_acc_reg   <= sum_next;
      out_acted_reg <= acted_next;
      out_sat_reg   <= sat_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_acc   = out_acc_reg;
  assign out_acted = out_acted_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_calc_multi.sv
// Directed bench for calc_multi: default 4x12 instance plus a 2x4 instance for saturation.
module tb_calc_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: N_CH=4, ACC_W=12
  logic        a_in_valid, a_in_ready, a_in_first, a_in_last, a_in_mode;
  logic [3:0]  a_in_w, a_in_x;
  logic [11:0] a_thr;
  logic        a_out_valid, a_out_ready;
  logic [47:0] a_out_acc;
  logic [3:0]  a_out_acted, a_out_sat;

  // Instance b: N_CH=2, ACC_W=4
  logic        b_in_valid, b_in_ready, b_in_first, b_in_last, b_in_mode;
  logic [1:0]  b_in_w, b_in_x;
  logic [3:0]  b_thr;
  logic        b_out_valid, b_out_ready;
  logic [7:0]  b_out_acc;
  logic [1:0]  b_out_acted, b_out_sat;

  int vectors = 0;
  int miscompares = 0;

  calc_multi #(.N_CH(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_first(a_in_first), .in_last(a_in_last),
    .in_mode(a_in_mode), .in_w(a_in_w), .in_x(a_in_x), .thr(a_thr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc),
    .out_acted(a_out_acted), .out_sat(a_out_sat)
  );

  calc_multi #(.N_CH(2), .ACC_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_first(b_in_first), .in_last(b_in_last),
    .in_mode(b_in_mode), .in_w(b_in_w), .in_x(b_in_x), .thr(b_thr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc),
    .out_acted(b_out_acted), .out_sat(b_out_sat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic beat_a(input logic first, input logic last, input logic mode,
                        input logic [3:0] w, input logic [3:0] x, input logic [11:0] t);
    a_in_valid = 1'b1; a_in_first = first; a_in_last = last; a_in_mode = mode;
    a_in_w = w; a_in_x = x; a_thr = t;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic first, input logic last, input logic mode,
                        input logic [1:0] w, input logic [1:0] x, input logic [3:0] t);
    b_in_valid = 1'b1; b_in_first = first; b_in_last = last; b_in_mode = mode;
    b_in_w = w; b_in_x = x; b_thr = t;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_first = 0; a_in_last = 0; a_in_mode = 0; a_in_w = 0; a_in_x = 0;
    a_thr = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_first = 0; b_in_last = 0; b_in_mode = 0; b_in_w = 0; b_in_x = 0;
    b_thr = 0; b_out_ready = 1;

    // 1. reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_acc",   64'(a_out_acc),   64'd0);
    chk("rst_a_sat",   64'(a_out_sat),   64'd0);
    chk("rst_a_acted", 64'(a_out_acted), 64'd0);
    chk("rst_a_ready", 64'(a_in_ready),  64'd1);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_ready", 64'(b_in_ready),  64'd1);

    // 2. bipolar three-beat vector
    beat_a(1, 0, 0, 4'b0111, 4'b0101, 12'd0);
    beat_a(0, 0, 0, 4'b0111, 4'b0001, 12'd0);
    chk("bip_mid_valid", 64'(a_out_valid), 64'd0);
    beat_a(0, 1, 0, 4'b0111, 4'b0101, 12'd0);
    chk("bip_valid", 64'(a_out_valid), 64'd1);
    chk("bip_acc",   64'(a_out_acc),   64'h003_001_FFD_003);
    chk("bip_acted", 64'(a_out_acted), 64'b1101);
    chk("bip_sat",   64'(a_out_sat),   64'd0);
    @(posedge clk); #1;
    chk("bip_consumed", 64'(a_out_valid), 64'd0);

    // 3. unipolar single beat
    beat_a(1, 1, 1, 4'b1010, 4'b1100, 12'd1);
    chk("uni_acc",   64'(a_out_acc),   64'h001_000_000_001);
    chk("uni_acted", 64'(a_out_acted), 64'b1001);
    @(posedge clk); #1;

    // 4. saturation on the narrow instance
    for (int i = 0; i < 10; i++)
      beat_b(i == 0, i == 9, 0, 2'b11, 2'b01, 4'd0);
    chk("sat_valid", 64'(b_out_valid), 64'd1);
    chk("sat_acc",   64'(b_out_acc),   64'h87);
    chk("sat_sat",   64'(b_out_sat),   64'b11);
    chk("sat_acted", 64'(b_out_acted), 64'b01);
    beat_b(1, 0, 0, 2'b11, 2'b11, 4'd0);
    beat_b(0, 1, 0, 2'b11, 2'b11, 4'd0);
    chk("sat2_acc", 64'(b_out_acc), 64'h22);
    chk("sat2_sat", 64'(b_out_sat), 64'b00);

    // 5. backpressure
    a_out_ready = 1'b0;
    beat_a(1, 1, 0, 4'b1111, 4'b1111, 12'd0);
    chk("bp_first_acc", 64'(a_out_acc), 64'h001_001_001_001);
    chk("bp_ready_low", 64'(a_in_ready), 64'd0);
    a_in_valid = 1; a_in_first = 1; a_in_last = 1; a_in_mode = 0;
    a_in_w = 4'b0000; a_in_x = 4'b1111; a_thr = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
    chk("bp_hold_acc",   64'(a_out_acc),   64'h001_001_001_001);
    chk("bp_hold_acted", 64'(a_out_acted), 64'b1111);
    chk("bp_hold_ready", 64'(a_in_ready),  64'd0);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_valid", 64'(a_out_valid), 64'd1);
    chk("bp_second_acc",   64'(a_out_acc),   64'hFFF_FFF_FFF_FFF);
    chk("bp_second_acted", 64'(a_out_acted), 64'b0000);
    a_in_mode = 1; a_in_w = 4'b0101; a_in_x = 4'b0000;
    @(posedge clk); #1;
    chk("stream1_valid", 64'(a_out_valid), 64'd1);
    chk("stream1_acc",   64'(a_out_acc),   64'h001_000_001_000);
    a_in_mode = 0; a_in_w = 4'b0011; a_in_x = 4'b0011;
    @(posedge clk); #1;
    chk("stream2_valid", 64'(a_out_valid), 64'd1);
    chk("stream2_acc",   64'(a_out_acc),   64'h001_001_001_001);
    a_in_w = 4'b1100; a_in_x = 4'b0011;
    @(posedge clk); #1;
    chk("stream3_acc", 64'(a_out_acc), 64'hFFF_FFF_FFF_FFF);
    a_in_valid = 0;
    @(posedge clk); #1;
    chk("stream_drain", 64'(a_out_valid), 64'd0);

    // 6. reset mid-vector, with a result pending behind backpressure
    a_out_ready = 1'b0;
    beat_a(1, 1, 0, 4'b1111, 4'b0000, 12'd0);
    beat_a(1, 0, 0, 4'b1111, 4'b1111, 12'd0);
    a_out_ready = 1'b1;
    beat_a(0, 0, 0, 4'b1111, 4'b1111, 12'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_acc",   64'(a_out_acc),   64'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_stale", 64'(a_out_valid), 64'd0);
    beat_a(0, 1, 0, 4'b1111, 4'b1111, 12'd0);
    chk("mid_rst_res_valid", 64'(a_out_valid), 64'd1);
    chk("mid_rst_res_acc",   64'(a_out_acc),   64'h001_001_001_001);
    chk("mid_rst_res_sat",   64'(a_out_sat),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
